multiplexor_n_canales: RTL and testbench



---
 rtl/multiplexor_n_canales.sv | 71 +++++++
 tb/tb_multiplexor_n_canales.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/multiplexor_n_canales.sv
// multiplexor_n_canales: N-channel registered stream mux, fixed-select or round-robin arbitration.
// Defining MUX_CONTADOR_EN adds a wrapping 16-bit transfer counter on Transferencias.
module multiplexor_n_canales #(
    parameter int DB = 16,
    parameter int N = 4,
    localparam int SW = (N > 1) ? $clog2(N) : 1
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic [N*DB-1:0] Datos,
    input  logic [N-1:0]    Validos,
    output logic [N-1:0]    Listos,
    input  logic [SW-1:0]   Sel,
    input  logic            Modo,
    output logic [DB-1:0]   Salida,
    output logic            SalidaValida,
    input  logic            SalidaLista,
    output logic [SW-1:0]   CanalSalida
`ifdef MUX_CONTADOR_EN
    ,
    output logic [15:0]     Transferencias
`endif
);
    logic [DB-1:0] canal [N];
    logic carga, hayGrant, transfer;
    logic [SW-1:0] grant, ultimo, cand;
    for (genvar i = 0; i < N; i++) begin : g_canal
        assign canal[i] = Datos[i*DB +: DB];
    end
    // Round-robin search starts just after the last granted channel
    always_comb begin
        carga = !SalidaValida || SalidaLista;
        grant = Sel;
        hayGrant = int'(Sel) < N;
        cand = '0;
        if (Modo) begin
            grant = '0;
            hayGrant = 1'b0;
            for (int k = 1; k <= N; k++) begin
                cand = SW'((int'(ultimo) + k) % N);
                if (!hayGrant && Validos[cand]) begin
                    grant = cand;
                    hayGrant = 1'b1;
                end
            end
        end
        Listos = (hayGrant && carga) ? N'(1) << grant : '0;
        transfer = |(Validos & Listos);
    end
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Salida <= '0;
            SalidaValida <= 1'b0;
            CanalSalida <= '0;
            ultimo <= SW'(N - 1);
        end else if (transfer) begin
            Salida <= canal[grant];
            CanalSalida <= grant;
            SalidaValida <= 1'b1;
            ultimo <= Modo ? grant : ultimo;
        end else if (SalidaLista) begin
            SalidaValida <= 1'b0;
        end
    end
`ifdef MUX_CONTADOR_EN
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) Transferencias <= '0;
        else if (transfer) Transferencias <= Transferencias + 16'd1;
    end
`endif
endmodule

// File: tb/tb_multiplexor_n_canales.sv
// tb_multiplexor_n_canales: directed scoreboard bench for the N=4 mux plus an N=3 instance for invalid select.
module tb_multiplexor_n_canales;
    logic Clk, Reset_n;
    logic [63:0] Datos;
    logic [3:0] Validos, Listos;
    logic [1:0] Sel, CanalSalida;
    logic Modo, SalidaValida, SalidaLista;
    logic [15:0] Salida;
    logic [47:0] Datos3;
    logic [2:0] Validos3, Listos3;
    logic [1:0] Sel3, CanalSalida3;
    logic Modo3, SalidaValida3, SalidaLista3;
    logic [15:0] Salida3;
`ifdef MUX_CONTADOR_EN
    logic [15:0] Transferencias, Transferencias3;
`endif
    typedef struct packed { logic [15:0] d; logic [1:0] c; } exp_t;
    exp_t q[$];
    int errors = 0, checks = 0;
    logic mValid;
    logic [15:0] mData, mCnt, held;
    logic [1:0] mCh, mUlt;

    multiplexor_n_canales #(.DB(16), .N(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .Datos(Datos), .Validos(Validos), .Listos(Listos),
        .Sel(Sel), .Modo(Modo), .Salida(Salida), .SalidaValida(SalidaValida),
        .SalidaLista(SalidaLista), .CanalSalida(CanalSalida)
`ifdef MUX_CONTADOR_EN
        , .Transferencias(Transferencias)
`endif
    );
    multiplexor_n_canales #(.DB(16), .N(3)) dut3 (
        .Clk(Clk), .Reset_n(Reset_n), .Datos(Datos3), .Validos(Validos3), .Listos(Listos3),
        .Sel(Sel3), .Modo(Modo3), .Salida(Salida3), .SalidaValida(SalidaValida3),
        .SalidaLista(SalidaLista3), .CanalSalida(CanalSalida3)
`ifdef MUX_CONTADOR_EN
        , .Transferencias(Transferencias3)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mValid = 1'b0; mData = '0; mCh = '0; mUlt = 2'd3; mCnt = '0;
        q.delete();
    endtask

    task automatic newData();
        for (int i = 0; i < 4; i++) Datos[i*16 +: 16] = 16'($urandom);
    endtask

    // Called just after a falling edge with inputs already driven
    task automatic cycle();
        logic [3:0] expL;
        logic xfer;
        int ch;
        exp_t e;
        #1;
        expL = '0;
        ch = 0;
        if (Modo) begin
            for (int k = 1; k <= 4; k++)
                if (expL == 0 && Validos[(int'(mUlt) + k) % 4]) expL = 4'b1 << ((int'(mUlt) + k) % 4);
        end else expL = 4'b1 << Sel;
        if (mValid && !SalidaLista) expL = '0;
        chk("listos", {28'd0, Listos}, {28'd0, expL});
        xfer = |(expL & Validos);
        for (int i = 0; i < 4; i++) if (expL[i]) ch = i;
        if (xfer) q.push_back({Datos[ch*16 +: 16], 2'(ch)});
        @(posedge Clk);
        #1;
        if (xfer) begin
            if (q.size() == 0) chk("queue_empty", 32'd1, 32'd0);
            else begin
                e = q.pop_front();
                mValid = 1'b1; mData = e.d; mCh = e.c;
                if (Modo) mUlt = e.c;
                mCnt = mCnt + 16'd1;
            end
        end else if (SalidaLista) mValid = 1'b0;
        chk("salida_valida", {31'd0, SalidaValida}, {31'd0, mValid});
        chk("salida", {16'd0, Salida}, {16'd0, mData});
        chk("canal_salida", {30'd0, CanalSalida}, {30'd0, mCh});
`ifdef MUX_CONTADOR_EN
        chk("transferencias", {16'd0, Transferencias}, {16'd0, mCnt});
`endif
        @(negedge Clk);
    endtask

    initial begin
        int seqA[5] = '{0, 1, 2, 3, 0};
        int seqB[4] = '{1, 3, 1, 3};
        Reset_n = 1'b0; Datos = '0; Validos = '0; Sel = '0; Modo = 1'b0; SalidaLista = 1'b0;
        Datos3 = '0; Validos3 = '0; Sel3 = '0; Modo3 = 1'b0; SalidaLista3 = 1'b0;
        modelReset();
        #12;
        chk("rst_salida", {16'd0, Salida}, 32'd0);
        chk("rst_valida", {31'd0, SalidaValida}, 32'd0);
        chk("rst_canal", {30'd0, CanalSalida}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        // Round-robin, all channels requesting
        Modo = 1'b1; Validos = 4'b1111; SalidaLista = 1'b1;
        for (int i = 0; i < 5; i++) begin
            newData();
            cycle();
            chk("rr_all_seq", {30'd0, CanalSalida}, 32'(seqA[i]));
        end
        Validos = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            newData();
            cycle();
            chk("rr_1010_seq", {30'd0, CanalSalida}, 32'(seqB[i]));
        end
        // Backpressure: held word must not move, no channel ready
        SalidaLista = 1'b0; Validos = 4'b1111;
        held = Salida;
        for (int i = 0; i < 5; i++) begin
            newData();
            cycle();
            chk("bp_hold", {16'd0, Salida}, {16'd0, held});
            chk("bp_listos", {28'd0, Listos}, 32'd0);
        end
        SalidaLista = 1'b1;
        newData();
        cycle();
        chk("bp_drain_load_valid", {31'd0, SalidaValida}, 32'd1);
        // Fixed select
        Modo = 1'b0; Sel = 2'd2; Validos = 4'b0100;
        newData();
        Datos[32 +: 16] = 16'hBEEF;
        cycle();
        chk("fix_data", {16'd0, Salida}, 32'hBEEF);
        chk("fix_canal", {30'd0, CanalSalida}, 32'd2);
        chk("fix_valid", {31'd0, SalidaValida}, 32'd1);
        Sel = 2'd3;
        cycle();
        chk("fix_sel3_no_xfer", {31'd0, SalidaValida}, 32'd0);
        chk("fix_sel3_hold", {16'd0, Salida}, 32'hBEEF);
        // Out-of-range select on a 3-channel instance
        Modo3 = 1'b0; Sel3 = 2'd3; Validos3 = 3'b111; SalidaLista3 = 1'b1;
        Datos3 = {16'h3333, 16'h2222, 16'h1111};
        #1;
        chk("n3_sel3_listos", {29'd0, Listos3}, 32'd0);
        @(posedge Clk);
        #1;
        chk("n3_sel3_valid", {31'd0, SalidaValida3}, 32'd0);
        @(negedge Clk);
        Sel3 = 2'd2;
        #1;
        chk("n3_sel2_listos", {29'd0, Listos3}, 32'd4);
        @(posedge Clk);
        #1;
        chk("n3_sel2_data", {16'd0, Salida3}, 32'h3333);
        chk("n3_sel2_canal", {30'd0, CanalSalida3}, 32'd2);
        @(negedge Clk);
        // Asynchronous reset while a word is held
        Modo = 1'b1; Validos = 4'b1111; SalidaLista = 1'b0;
        newData();
        cycle();
        chk("pre_rst_valid", {31'd0, SalidaValida}, 32'd1);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("arst_salida", {16'd0, Salida}, 32'd0);
        chk("arst_valid", {31'd0, SalidaValida}, 32'd0);
        chk("arst_canal", {30'd0, CanalSalida}, 32'd0);
        modelReset();
        @(negedge Clk);
        Reset_n = 1'b1;
        SalidaLista = 1'b1;
        newData();
        cycle();
        chk("post_rst_grant0", {30'd0, CanalSalida}, 32'd0);
`ifdef MUX_CONTADOR_EN
        Reset_n = 1'b0;
        #1;
        chk("cnt_rst", {16'd0, Transferencias}, 32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;
        repeat (65537) @(negedge Clk);
        chk("cnt_wrap", {16'd0, Transferencias}, 32'd1);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
